// File: rtl/trap_sequencer.sv
// Machine-mode trap sequencer: takes exceptions, interrupts and MRET,
// sequences the CSR saves/restores and owns the CSR file write port.
module trap_sequencer #(
    parameter int XLEN      = 32,
    parameter bit VECTOR_EN = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            illegal_instr,
    input  logic            mret,
    input  logic [XLEN-1:0] instr_pc,
    input  logic [31:0]     instr_bits,
    input  logic            irq_ext,
    input  logic            irq_timer,
    input  logic [XLEN-1:0] mstatus_rdata,
    input  logic [XLEN-1:0] mie_rdata,
    input  logic [XLEN-1:0] mtvec_rdata,
    input  logic [XLEN-1:0] mepc_rdata,
    input  logic            pipe_csr_we,
    input  logic [11:0]     pipe_csr_addr,
    input  logic [XLEN-1:0] pipe_csr_wdata,
    output logic            csr_we,
    output logic [11:0]     csr_addr,
    output logic [XLEN-1:0] csr_wdata,
    output logic            stall,
    output logic            flush,
    output logic            pc_redirect,
    output logic [XLEN-1:0] pc_target
);

    typedef enum logic [2:0] {
        IDLE, W_EPC, W_CAUSE, W_TVAL, W_STAT, RESTORE, REDIR
    } state_t;

    localparam logic [XLEN-1:0] CAUSE_ILL = XLEN'(2);
    localparam logic [XLEN-1:0] CAUSE_EXT = {1'b1, (XLEN-1)'(11)};
    localparam logic [XLEN-1:0] CAUSE_TMR = {1'b1, (XLEN-1)'(7)};

    state_t          r_state;
    logic [XLEN-1:0] r_epc;
    logic [XLEN-1:0] r_cause;
    logic [XLEN-1:0] r_tval;
    logic [XLEN-1:0] r_target;

    logic            w_idle;
    logic            w_int_ok;
    logic            w_take_ext;
    logic            w_take_tmr;
    logic            w_is_int;
    logic            w_accept;
    logic [XLEN-1:0] w_cause;
    logic [XLEN-1:0] w_tval;
    logic [XLEN-1:0] w_base;
    logic [XLEN-1:0] w_trap_tgt;
    logic [XLEN-1:0] w_stat_trap;
    logic [XLEN-1:0] w_stat_ret;
    logic            w_unused;

    // Interrupts wait while the pipeline is writing a CSR so MIE/mie are settled.
    assign w_idle     = (r_state == IDLE);
    assign w_int_ok   = mstatus_rdata[3] & ~pipe_csr_we;
    assign w_take_ext = w_int_ok & irq_ext & mie_rdata[11];
    assign w_take_tmr = w_int_ok & irq_timer & mie_rdata[7];
    assign w_is_int   = ~illegal_instr & ~mret;
    assign w_accept   = w_idle & rst &
                        (illegal_instr | mret | w_take_ext | w_take_tmr);
    assign w_unused   = ^{mie_rdata, r_epc[1:0]};

    always_comb begin
        w_cause = CAUSE_TMR;
        w_tval  = '0;
        unique case (1'b1)
            illegal_instr: begin
                w_cause = CAUSE_ILL;
                w_tval  = XLEN'(instr_bits);
            end
            mret:       w_cause = CAUSE_ILL;
            w_take_ext: w_cause = CAUSE_EXT;
            default:    w_cause = CAUSE_TMR;
        endcase
    end

    assign w_base = {mtvec_rdata[XLEN-1:2], 2'b00};

    always_comb begin
        w_trap_tgt = w_base;
        if (VECTOR_EN && w_is_int && mtvec_rdata[1:0] == 2'b01)
            w_trap_tgt = w_base + XLEN'({w_cause[4:0], 2'b00});
    end

    always_comb begin
        w_stat_trap        = mstatus_rdata;
        w_stat_trap[7]     = mstatus_rdata[3];
        w_stat_trap[3]     = 1'b0;
        w_stat_trap[12:11] = 2'b11;
        w_stat_ret         = mstatus_rdata;
        w_stat_ret[3]      = mstatus_rdata[7];
        w_stat_ret[7]      = 1'b1;
        w_stat_ret[12:11]  = 2'b11;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state  <= IDLE;
            r_epc    <= '0;
            r_cause  <= '0;
            r_tval   <= '0;
            r_target <= '0;
        end else begin
            unique case (r_state)
                IDLE: if (w_accept) begin
                    r_epc   <= instr_pc;
                    r_cause <= w_cause;
                    r_tval  <= w_tval;
                    if (mret && !illegal_instr) begin
                        r_state <= RESTORE;
                    end else begin
                        r_state  <= W_EPC;
                        r_target <= w_trap_tgt;
                    end
                end
                W_EPC:   r_state <= W_CAUSE;
                W_CAUSE: r_state <= W_TVAL;
                W_TVAL:  r_state <= W_STAT;
                W_STAT:  r_state <= REDIR;
                RESTORE: begin
                    r_target <= mepc_rdata;
                    r_state  <= REDIR;
                end
                REDIR:   r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    always_comb begin
        csr_we    = 1'b0;
        csr_addr  = '0;
        csr_wdata = '0;
        unique case (r_state)
            IDLE: if (!w_accept) begin
                csr_we    = pipe_csr_we;
                csr_addr  = pipe_csr_addr;
                csr_wdata = pipe_csr_wdata;
            end
            W_EPC: begin
                csr_we    = 1'b1;
                csr_addr  = 12'h341;
                csr_wdata = {r_epc[XLEN-1:2], 2'b00};
            end
            W_CAUSE: begin
                csr_we    = 1'b1;
                csr_addr  = 12'h342;
                csr_wdata = r_cause;
            end
            W_TVAL: begin
                csr_we    = 1'b1;
                csr_addr  = 12'h343;
                csr_wdata = r_tval;
            end
            W_STAT: begin
                csr_we    = 1'b1;
                csr_addr  = 12'h300;
                csr_wdata = w_stat_trap;
            end
            RESTORE: begin
                csr_we    = 1'b1;
                csr_addr  = 12'h300;
                csr_wdata = w_stat_ret;
            end
            default: ;
        endcase
    end

    assign stall       = ~w_idle | w_accept;
    assign flush       = w_accept;
    assign pc_redirect = (r_state == REDIR);
    assign pc_target   = r_target;

endmodule
